muldiv_seq: RTL

- Parametrised, multi-cycle integer multiply/divide unit implementing the full RV32M operation set.
- Successor to the single-cycle combinational ALU, generalised in WIDTH.
- Sits beside the ALU in the execute stage; the core stalls on a valid/ready handshake while the unit iterates one bit per cycle.
- Produces the same zero/negative result flags as the ALU, plus a divide-by-zero indication.

---
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: one bit per cycle, shift-add multiply, restoring divide.
// Define MULDIV_FAST_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_seq #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg, r_sign_a, r_dbz;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero, r_negative, r_div_by_zero;

  logic                 w_sa_en, w_sb_en, w_a_neg, w_b_neg, w_dbz_in, w_fast;
  logic [WIDTH-1:0]     w_a_abs, w_b_abs;
  logic [WIDTH:0]       w_mul_sum, w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem, w_fix_res;

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign zero        = r_zero;
  assign negative    = r_negative;
  assign div_by_zero = r_div_by_zero;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
  assign w_sa_en  = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
  assign w_sb_en  = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
  assign w_a_neg  = w_sa_en & a[WIDTH-1];
  assign w_b_neg  = w_sb_en & b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;
  assign w_dbz_in = op[2] & (b == '0);

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_b});
  assign w_diff    = w_trial[WIDTH-1:0] - r_b;

`ifdef MULDIV_FAST_EN
  logic             w_ovf_in, w_mz_in;
  logic [WIDTH-1:0] w_fast_res;
  assign w_ovf_in   = op[2] & ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
  assign w_mz_in    = ~op[2] & ((a == '0) | (b == '0));
  assign w_fast     = w_dbz_in | w_ovf_in | w_mz_in;
  assign w_fast_res = w_dbz_in ? (op[1] ? a : {WIDTH{1'b1}}) :
                      w_ovf_in ? (op[1] ? {WIDTH{1'b0}} : a) : {WIDTH{1'b0}};
`else
  assign w_fast = 1'b0;
`endif

  // divide-by-zero quotient overrides the sign-corrected all-ones pattern
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    if (r_dbz) w_quo = {WIDTH{1'b1}};
    w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    case (r_op)
      3'b000:                 w_fix_res = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) w_state_nxt = w_fast ? S_DONE : S_CALC;
        S_CALC: if (r_cnt == LAST) w_state_nxt = S_FIX;
        S_FIX:  w_state_nxt = S_DONE;
        S_DONE: if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_neg         <= 1'b0;
      r_sign_a      <= 1'b0;
      r_dbz         <= 1'b0;
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_negative    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op     <= op;
          r_a      <= w_a_abs;
          r_b      <= w_b_abs;
          r_neg    <= w_a_neg ^ w_b_neg;
          r_sign_a <= w_a_neg;
          r_dbz    <= w_dbz_in;
          r_acc    <= '0;
          r_cnt    <= '0;
`ifdef MULDIV_FAST_EN
          if (w_fast) begin
            r_result      <= w_fast_res;
            r_zero        <= (w_fast_res == '0);
            r_negative    <= w_fast_res[WIDTH-1];
            r_div_by_zero <= w_dbz_in;
          end
`endif
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op[2]) begin
            r_acc <= {(w_ge ? w_diff : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
            r_a   <= r_a << 1;
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_b   <= r_b >> 1;
          end
        end
        S_FIX: begin
          r_result      <= w_fix_res;
          r_zero        <= (w_fix_res == '0);
          r_negative    <= w_fix_res[WIDTH-1];
          r_div_by_zero <= r_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule
